// File: rtl/eb1_ifu_fetch_buf.sv
// eb1_ifu_fetch_buf
//   In-order fetch packet buffer between the fetch-pipe control stage and the
//   aligner/decode side. Each F-stage hit packet ({pc[31:1], data[31:0]}) is
//   written at the tail; the two oldest packets are presented on fb_*.
//   Decode retires one or two packets per cycle and the retire count is
//   echoed on ifu_fb_consume1/2 so fetch control can track occupancy.
//
// Parameters
//   FB_DEPTH  number of packet entries (power of two, >= 2)
//   FB_PTR_W  log2(FB_DEPTH)
//
// Ports
//   clk, rst_l          core clock, asynchronous active-low reset
//   scan_mode           scan enable (no functional effect)
//   ifc_fetch_req_f     F-stage fetch request valid
//   ic_hit_f            I-cache/ICCM hit for the F request
//   ifc_fetch_addr_f    F-stage fetch address [31:1]
//   ic_data_f           F-stage fetch data
//   exu_flush_final     pipeline flush; empties the buffer, highest priority
//   dec_take1/2         decode retires one/two packets this cycle
//   ifu_fb_consume1/2   one/two packets actually retired this cycle
//   fb_valid            [0] head valid, [1] head+1 valid
//   fb_pc0/1, fb_data0/1 head and head+1 packets (zero when not valid)
//   fb_count            occupied entries, 0..FB_DEPTH
//   fb_overflow         a hit arrived with no free slot and was dropped
//
// Optional feature (macro EB1_IFU_FB_PARITY_EN)
//   Adds a stored even-parity bit per entry, input fb_inject_perr (inverts the
//   parity bit written at push) and output fb_parity_err0 (head parity error).

module eb1_ifu_fetch_buf #(
  parameter int FB_DEPTH = 4,
  parameter int FB_PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                scan_mode,
  input  logic                ifc_fetch_req_f,
  input  logic                ic_hit_f,
  input  logic [30:0]         ifc_fetch_addr_f,
  input  logic [31:0]         ic_data_f,
  input  logic                exu_flush_final,
  input  logic                dec_take1,
  input  logic                dec_take2,
`ifdef EB1_IFU_FB_PARITY_EN
  input  logic                fb_inject_perr,
  output logic                fb_parity_err0,
`endif
  output logic                ifu_fb_consume1,
  output logic                ifu_fb_consume2,
  output logic [1:0]          fb_valid,
  output logic [30:0]         fb_pc0,
  output logic [30:0]         fb_pc1,
  output logic [31:0]         fb_data0,
  output logic [31:0]         fb_data1,
  output logic [FB_PTR_W:0]   fb_count,
  output logic                fb_overflow
);

  localparam int CNT_W = FB_PTR_W + 1;
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FB_DEPTH);
  localparam logic [FB_PTR_W-1:0] PTR_ONE  = FB_PTR_W'(1);

  // scan_mode only reaches flop cells in the physical netlist
  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;

  // Pointer / occupancy state
  logic [FB_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FB_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // Entry storage (not reset; written only under push_ok)
  logic [30:0] entry_pc_q   [FB_DEPTH];
  logic [31:0] entry_data_q [FB_DEPTH];

  logic                push;
  logic                c1, c2;
  logic [CNT_W-1:0]    pops;
  logic [CNT_W-1:0]    cnt_after_pop;
  logic                push_ok;
  logic                ovf;
  logic [FB_PTR_W-1:0] rd_ptr1;

  always_comb begin
    push = ifc_fetch_req_f & ic_hit_f & ~exu_flush_final;

    // take2 with a single packet degrades to a single retire
    c2 = dec_take2 & (count_q >= CNT_TWO);
    c1 = ~c2 & (dec_take1 | dec_take2) & (count_q >= CNT_ONE);
    pops = c2 ? CNT_TWO : (c1 ? CNT_ONE : '0);

    // Slots freed by this cycle's pops are available to this cycle's push
    cnt_after_pop = count_q - pops;
    push_ok       = push & (cnt_after_pop != CNT_FULL);
    ovf           = push & ~push_ok;

    if (exu_flush_final) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // pops <= 2 < 2*FB_DEPTH, so truncating to the pointer width is the wrap
      rd_ptr_d = rd_ptr_q + pops[FB_PTR_W-1:0];
      wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      count_d  = cnt_after_pop + CNT_W'(push_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      entry_pc_q[wr_ptr_q]   <= ifc_fetch_addr_f;
      entry_data_q[wr_ptr_q] <= ic_data_f;
    end
  end

`ifdef EB1_IFU_FB_PARITY_EN
  logic entry_par_q [FB_DEPTH];
  logic wr_par_d;

  always_comb begin
    wr_par_d = (^{ifc_fetch_addr_f, ic_data_f}) ^ fb_inject_perr;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      entry_par_q[wr_ptr_q] <= wr_par_d;
    end
  end

  assign fb_parity_err0 = fb_valid[0] &
    ((^{entry_pc_q[rd_ptr_q], entry_data_q[rd_ptr_q]}) != entry_par_q[rd_ptr_q]);
`endif

  assign rd_ptr1 = rd_ptr_q + PTR_ONE;

  assign ifu_fb_consume1 = c1 & ~exu_flush_final;
  assign ifu_fb_consume2 = c2 & ~exu_flush_final;
  assign fb_overflow     = ovf;
  assign fb_count        = count_q;
  assign fb_valid        = {count_q >= CNT_TWO, count_q >= CNT_ONE};

  // Invalid slots are driven to zero so never-written storage cannot leak X
  assign fb_pc0   = fb_valid[0] ? entry_pc_q[rd_ptr_q]   : '0;
  assign fb_data0 = fb_valid[0] ? entry_data_q[rd_ptr_q] : '0;
  assign fb_pc1   = fb_valid[1] ? entry_pc_q[rd_ptr1]    : '0;
  assign fb_data1 = fb_valid[1] ? entry_data_q[rd_ptr1]  : '0;

endmodule

// File: tb/tb_eb1_ifu_fetch_buf.sv
module tb_eb1_ifu_fetch_buf;

  localparam int D  = 4;
  localparam int PW = 2;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        scan_mode;
  logic        ifc_fetch_req_f;
  logic        ic_hit_f;
  logic [30:0] ifc_fetch_addr_f;
  logic [31:0] ic_data_f;
  logic        exu_flush_final;
  logic        dec_take1;
  logic        dec_take2;
  logic        fb_inject_perr;
  logic        ifu_fb_consume1;
  logic        ifu_fb_consume2;
  logic [1:0]  fb_valid;
  logic [30:0] fb_pc0, fb_pc1;
  logic [31:0] fb_data0, fb_data1;
  logic [PW:0] fb_count;
  logic        fb_overflow;
`ifdef EB1_IFU_FB_PARITY_EN
  logic        fb_parity_err0;
`endif

  eb1_ifu_fetch_buf #(.FB_DEPTH(D), .FB_PTR_W(PW)) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .scan_mode        (scan_mode),
    .ifc_fetch_req_f  (ifc_fetch_req_f),
    .ic_hit_f         (ic_hit_f),
    .ifc_fetch_addr_f (ifc_fetch_addr_f),
    .ic_data_f        (ic_data_f),
    .exu_flush_final  (exu_flush_final),
    .dec_take1        (dec_take1),
    .dec_take2        (dec_take2),
`ifdef EB1_IFU_FB_PARITY_EN
    .fb_inject_perr   (fb_inject_perr),
    .fb_parity_err0   (fb_parity_err0),
`endif
    .ifu_fb_consume1  (ifu_fb_consume1),
    .ifu_fb_consume2  (ifu_fb_consume2),
    .fb_valid         (fb_valid),
    .fb_pc0           (fb_pc0),
    .fb_pc1           (fb_pc1),
    .fb_data0         (fb_data0),
    .fb_data1         (fb_data1),
    .fb_count         (fb_count),
    .fb_overflow      (fb_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain in-order queue of packets
  typedef struct {
    logic [30:0] pc;
    logic [31:0] data;
    bit          inj;
  } pkt_t;

  pkt_t mq[$];

  function automatic int model_pops();
    int n = mq.size();
    if (dec_take2 && n >= 2) return 2;
    if ((dec_take1 || dec_take2) && n >= 1) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l || exu_flush_final) begin
      mq.delete();
    end else begin
      int n, p;
      pkt_t pk;
      n = mq.size();
      p = model_pops();
      repeat (p) void'(mq.pop_front());
      if (ifc_fetch_req_f && ic_hit_f && (n - p < D)) begin
        pk.pc   = ifc_fetch_addr_f;
        pk.data = ic_data_f;
`ifdef EB1_IFU_FB_PARITY_EN
        pk.inj  = fb_inject_perr;
`else
        pk.inj  = 1'b0;
`endif
        mq.push_back(pk);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_l) begin
      int n, p;
      bit push;
      n    = mq.size();
      p    = model_pops();
      push = ifc_fetch_req_f && ic_hit_f && !exu_flush_final;
      chk("consume1", ifu_fb_consume1, !exu_flush_final && p == 1);
      chk("consume2", ifu_fb_consume2, !exu_flush_final && p == 2);
      chk("overflow", fb_overflow, push && (n - p == D));
      chk("count", fb_count, n);
      chk("valid", fb_valid, {n >= 2, n >= 1});
      if (n >= 1) begin
        chk("pc0", fb_pc0, mq[0].pc);
        chk("data0", fb_data0, mq[0].data);
      end
      if (n >= 2) begin
        chk("pc1", fb_pc1, mq[1].pc);
        chk("data1", fb_data1, mq[1].data);
      end
`ifdef EB1_IFU_FB_PARITY_EN
      chk("perr0", fb_parity_err0, n >= 1 && mq[0].inj);
`endif
    end
  end

  task automatic drive(input logic req, input logic hit, input logic [30:0] a,
                       input logic [31:0] d, input logic fl, input logic t1,
                       input logic t2, input logic inj);
    @(posedge clk);
    #1;
    ifc_fetch_req_f  = req;
    ic_hit_f         = hit;
    ifc_fetch_addr_f = a;
    ic_data_f        = d;
    exu_flush_final  = fl;
    dec_take1        = t1;
    dec_take2        = t2;
    fb_inject_perr   = inj;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_l = 1'b0;
    scan_mode = 1'b0;
    ifc_fetch_req_f = 1'b0;
    ic_hit_f = 1'b0;
    ifc_fetch_addr_f = '0;
    ic_data_f = '0;
    exu_flush_final = 1'b0;
    dec_take1 = 1'b0;
    dec_take2 = 1'b0;
    fb_inject_perr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_l = 1'b1;
    dec_take2 = 1'b1;
    @(negedge clk);
    chk("rst_count", fb_count, 0);
    chk("rst_valid", fb_valid, 2'b00);
    chk("rst_c1", ifu_fb_consume1, 0);
    chk("rst_c2", ifu_fb_consume2, 0);
    chk("rst_ovf", fb_overflow, 0);

    // Fill to full
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b1, 31'h100 + 31'(2 * i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("full_count", fb_count, 4);
    chk("full_pc0", fb_pc0, 31'h100);
    chk("full_pc1", fb_pc1, 31'h102);
    chk("full_data1", fb_data1, 32'hA1);
    drive(1'b1, 1'b1, 31'h10A, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_pulse", fb_overflow, 1);
    idle();
    @(negedge clk);
    chk("ovf_count", fb_count, 4);
    chk("ovf_clear", fb_overflow, 0);

    // Full with take2 and simultaneous push: freed slot reused, wraps
    drive(1'b1, 1'b1, 31'h108, 32'hA4, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fullpop_c2", ifu_fb_consume2, 1);
    chk("fullpop_c1", ifu_fb_consume1, 0);
    chk("fullpop_ovf", fb_overflow, 0);
    idle();
    @(negedge clk);
    chk("fullpop_count", fb_count, 3);
    chk("fullpop_pc0", fb_pc0, 31'h104);
    chk("fullpop_pc1", fb_pc1, 31'h106);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("wrap_count", fb_count, 1);
    chk("wrap_pc0", fb_pc0, 31'h108);
    chk("wrap_data0", fb_data0, 32'hA4);

    // take2 with a single packet degrades to one retire
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("deg_c1", ifu_fb_consume1, 1);
    chk("deg_c2", ifu_fb_consume2, 0);
    idle();
    @(negedge clk);
    chk("deg_count", fb_count, 0);
    chk("deg_valid", fb_valid, 2'b00);

    // Flush beats push and take
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 31'h300 + 31'(2 * i), 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 31'h306, 32'hB3, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_c1", ifu_fb_consume1, 0);
    chk("flush_c2", ifu_fb_consume2, 0);
    chk("flush_ovf", fb_overflow, 0);
    drive(1'b1, 1'b1, 31'h200, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_count", fb_count, 0);
    idle();
    @(negedge clk);
    chk("post_flush_pc0", fb_pc0, 31'h200);
    chk("post_flush_count", fb_count, 1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

`ifdef EB1_IFU_FB_PARITY_EN
    drive(1'b1, 1'b1, 31'h400, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("perr_set", fb_parity_err0, 1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("perr_clear", fb_parity_err0, 0);
    chk("perr_count", fb_count, 0);
`endif

    // Randomized traffic; take rate varies by phase to sweep occupancy
    for (int ph = 0; ph < 6; ph++) begin
      int tk;
      tk = (ph % 3) * 3 + 1;
      for (int i = 0; i < 500; i++) begin
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
              31'($urandom), $urandom, $urandom_range(0, 49) == 0,
              $urandom_range(0, 9) < tk, $urandom_range(0, 9) < tk,
              $urandom_range(0, 7) == 0);
      end
    end
    idle();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eb1_ifu_fetch_buf.md
Name: eb1_ifu_fetch_buf

Overview:
- Fetch buffer sitting directly downstream of the fetch-pipe control stage.
- Captures each F-stage fetch packet (31-bit fetch address plus 32 bits of I-cache/ICCM data) on a hit.
- Holds up to FB_DEPTH packets in order and presents the two oldest to the aligner/decode side.
- Reports how many packets were retired each cycle as ifu_fb_consume1/ifu_fb_consume2, which the fetch control uses to mass-balance its own full model.

Parameters:
- FB_DEPTH, 4: number of packet entries; power of two, minimum 2.
- FB_PTR_W, 2: pointer width, log2(FB_DEPTH).

Ports:
- clk  input  1  core clock (ACTIVE_L2CLK domain)
- rst_l  input  1  asynchronous active-low reset
- scan_mode  input  1  scan enable; passed to flop cells, no functional effect
- ifc_fetch_req_f  input  1  fetch request valid in F
- ic_hit_f  input  1  I-cache/ICCM hit for the F request
- ifc_fetch_addr_f  input  31  F-stage fetch address [31:1]
- ic_data_f  input  32  fetch data for the F request
- exu_flush_final  input  1  pipeline flush
- dec_take1  input  1  decode retires one packet this cycle
- dec_take2  input  1  decode retires two packets this cycle
- ifu_fb_consume1  output  1  exactly one packet retired this cycle
- ifu_fb_consume2  output  1  two packets retired this cycle
- fb_valid  output  2  [0] head valid, [1] head+1 valid
- fb_pc0  output  31  head packet address
- fb_pc1  output  31  head+1 packet address
- fb_data0  output  32  head packet data
- fb_data1  output  32  head+1 packet data
- fb_count  output  FB_PTR_W+1  occupied entries, 0..FB_DEPTH
- fb_overflow  output  1  one-cycle pulse: a write arrived while full after pops and was dropped

Behaviour:
- Reset (rst_l low, asynchronous): rd_ptr=0, wr_ptr=0, count=0. All outputs 0. Entry storage is not reset.
- push = ifc_fetch_req_f & ic_hit_f & ~exu_flush_final.
- Consume (combinational, same cycle):
  - c2 = dec_take2 & (count>=2)
  - c1 = ~c2 & (dec_take1 | dec_take2) & (count>=1)
  - dec_take2 with count==1 degrades to c1.
  - Both takes with count==0 produce nothing.
  - dec_take1 & dec_take2 together behaves as dec_take2.
- ifu_fb_consume1 = c1 & ~exu_flush_final; ifu_fb_consume2 = c2 & ~exu_flush_final. Never both high.
- pops = 2*c2 + c1. Pops read stored entries only; a packet pushed this cycle is not bypassed to the outputs.
- Push accepted when count - pops < FB_DEPTH. The entry is written at wr_ptr and wr_ptr advances by 1 with modulo FB_DEPTH wrap.
- Push rejected when count - pops == FB_DEPTH: data dropped, fb_overflow=1 for that cycle, state unchanged apart from the pops.
- count_next = count - pops + push_accepted. A simultaneous push and pop while full is legal: the freed slot is reused.
- rd_ptr advances by pops, modulo FB_DEPTH.
- Flush (exu_flush_final=1):
  - Next cycle: rd_ptr=wr_ptr=0, count=0.
  - Same cycle: push ignored, consume outputs forced 0, fb_overflow forced 0.
  - Flush has priority over every other event.
- Read outputs, combinational from registered state:
  - fb_valid[0]=(count>=1), fb_valid[1]=(count>=2).
  - fb_pc0/fb_data0 = entry[rd_ptr]; fb_pc1/fb_data1 = entry[rd_ptr+1 mod FB_DEPTH].
  - Data on an invalid slot is don't-care but must not be X after the first write to that entry.
- fb_count = count register.
- Latency: a packet pushed in cycle N is visible on fb_* in cycle N+1.
- Single clock, no internal clock gating. Entry writes use enable flops.

Optional Feature:
- Macro: EB1_IFU_FB_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit over {pc[31:1], data[31:0]}, computed at push.
  - Adds output fb_parity_err0 (1 bit) = fb_valid[0] & (recomputed parity of head != stored bit).
  - Adds input fb_inject_perr (1 bit): when high at push, the stored parity bit is inverted.
  - Reset value of fb_parity_err0 is 0.
- Undefined: no parity storage, no extra ports; behaviour otherwise identical.

Test Plan:
- Reset then idle: after rst_l deasserts, fb_count=0, fb_valid=2'b00, consume outputs 0 even with dec_take2=1.
- Four hits at addrs 0x100,0x102,0x104,0x106 (data 0xA0..0xA3), no takes: fb_count=4, fb_pc0=0x100, fb_pc1=0x102. A fifth hit gives fb_overflow=1 and count stays 4.
- Full with dec_take2=1 and a simultaneous push (0x108): ifu_fb_consume2=1, count goes 4->3, head becomes 0x104, and 0x108 is last in order after wrap.
- count=1 with dec_take2=1: ifu_fb_consume1=1, ifu_fb_consume2=0, count=0, fb_valid=00 next cycle.
- count=3 with push, dec_take1 and exu_flush_final all =1: consume outputs 0, next cycle count=0. A following push of 0x200 then appears as fb_pc0=0x200.
- (EB1_IFU_FB_PARITY_EN) push with fb_inject_perr=1 into an empty buffer: next cycle fb_parity_err0=1. After dec_take1 retires it, fb_parity_err0=0.
